// File: rtl/comparison_pkg.sv
// Shared types for the sign-magnitude compare unit: op modes, FSM states, status bit indices.
package comparison_pkg;

  typedef enum logic [2:0] {
    CMP_LT  = 3'd0,
    CMP_LE  = 3'd1,
    CMP_EQ  = 3'd2,
    CMP_GT  = 3'd3,
    CMP_GE  = 3'd4,
    CMP_MIN = 3'd5,
    CMP_MAX = 3'd6,
    CMP_ACC = 3'd7
  } cmp_mode_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } cmp_state_e;

  localparam int ST_EQ = 0;
  localparam int ST_LT = 1;
  localparam int ST_GT = 2;
  localparam int ST_NZ = 3;

endpackage

// File: rtl/sm_compare.sv
// Combinational sign-magnitude compare; +0 and -0 are equal, nz flags any -0 operand.
module sm_compare #(
  parameter int M = 8
) (
  input  logic [M-1:0] a,
  input  logic [M-1:0] b,
  output logic         eq,
  output logic         lt,
  output logic         gt,
  output logic         nz
);

  logic         a_z, b_z;
  logic [M-2:0] am, bm;

  assign am  = a[M-2:0];
  assign bm  = b[M-2:0];
  assign a_z = ~|am;
  assign b_z = ~|bm;
  assign nz  = (a[M-1] & a_z) | (b[M-1] & b_z);

  always_comb begin
    eq = 1'b0;
    lt = 1'b0;
    gt = 1'b0;
    if (a_z && b_z) begin
      eq = 1'b1;
    end else if (a[M-1] != b[M-1]) begin
      lt = a[M-1];
      gt = b[M-1];
    end else if (am == bm) begin
      eq = 1'b1;
    end else if (!a[M-1]) begin
      lt = am < bm;
      gt = am > bm;
    end else begin
      // both negative: larger magnitude is the smaller value
      lt = am > bm;
      gt = am < bm;
    end
  end

endmodule

// File: rtl/comparison_seq.sv
// Registered handshaked sign-magnitude comparator with relational, min/max and running-max modes.
module comparison_seq
  import comparison_pkg::*;
#(
  parameter int M = 8,
  parameter int K = 8
) (
  input  logic         i_clk,
  input  logic         i_rsn,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [M-1:0] i_arg_A,
  input  logic [M-1:0] i_arg_B,
  input  logic [2:0]   i_mode,
  input  logic         i_acc_clr,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [K-1:0] cache_result,
  output logic [3:0]   cache_status
);

  if (K < M) begin : g_bad_k
    $error("comparison_seq: K must be >= M");
  end

  cmp_state_e   state, state_nxt;
  cmp_mode_e    mode_q;
  logic [M-1:0] a_q, b_q, acc;
  logic         acc_empty;

  logic         ab_eq, ab_lt, ab_gt, ab_nz;
  logic         ac_eq, ac_lt, ac_gt, ac_nz;
  logic [K-1:0] res_d;
  logic [3:0]   st_d;
  logic [M-1:0] acc_d;

  // -0 collapses to +0 so stored/returned operands have one zero encoding
  function automatic logic [M-1:0] norm(input logic [M-1:0] v);
    return {v[M-1] & |v[M-2:0], v[M-2:0]};
  endfunction

  function automatic logic [K-1:0] to_res(input logic [M-1:0] v);
    logic [K-1:0] r;
    r        = '0;
    r[M-2:0] = v[M-2:0];
    r[K-1]   = v[M-1] & |v[M-2:0];
    return r;
  endfunction

  function automatic logic [K-1:0] bool_res(input logic b);
    return {{(K-1){1'b0}}, b};
  endfunction

  sm_compare #(.M(M)) u_cmp_ab (
    .a(a_q), .b(b_q), .eq(ab_eq), .lt(ab_lt), .gt(ab_gt), .nz(ab_nz)
  );

  // acc is always normalised, so ac_nz reflects only A being -0
  sm_compare #(.M(M)) u_cmp_acc (
    .a(a_q), .b(acc), .eq(ac_eq), .lt(ac_lt), .gt(ac_gt), .nz(ac_nz)
  );

  assign o_ready = (state == S_IDLE);
  assign o_valid = (state == S_DONE);

  always_ff @(posedge i_clk or negedge i_rsn) begin
    if (!i_rsn) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (i_valid) state_nxt = S_CALC;
      S_CALC:  state_nxt = S_DONE;
      S_DONE:  if (i_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    res_d = '0;
    st_d  = '0;
    acc_d = acc;
    st_d[ST_EQ] = ab_eq;
    st_d[ST_LT] = ab_lt;
    st_d[ST_GT] = ab_gt;
    st_d[ST_NZ] = ab_nz;
    case (mode_q)
      CMP_LT:  res_d = bool_res(ab_lt);
      CMP_LE:  res_d = bool_res(ab_lt | ab_eq);
      CMP_EQ:  res_d = bool_res(ab_eq);
      CMP_GT:  res_d = bool_res(ab_gt);
      CMP_GE:  res_d = bool_res(ab_gt | ab_eq);
      CMP_MIN: res_d = to_res(ab_gt ? b_q : a_q);
      CMP_MAX: res_d = to_res(ab_lt ? b_q : a_q);
      CMP_ACC: begin
        if (acc_empty || ac_gt) acc_d = norm(a_q);
        res_d       = to_res(acc_d);
        st_d[ST_EQ] = ac_eq & ~acc_empty;
        st_d[ST_LT] = ac_lt & ~acc_empty;
        st_d[ST_GT] = ac_gt & ~acc_empty;
        st_d[ST_NZ] = ac_nz;
      end
      default: res_d = '0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rsn) begin
    if (!i_rsn) begin
      a_q          <= '0;
      b_q          <= '0;
      mode_q       <= CMP_LT;
      acc          <= '0;
      acc_empty    <= 1'b1;
      cache_result <= '0;
      cache_status <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          // a clear on the accept edge lands before the op reaches CALC
          if (i_acc_clr) begin
            acc       <= '0;
            acc_empty <= 1'b1;
          end
          if (i_valid) begin
            a_q    <= i_arg_A;
            b_q    <= i_arg_B;
            mode_q <= cmp_mode_e'(i_mode);
          end
        end
        S_CALC: begin
          cache_result <= res_d;
          cache_status <= st_d;
          if (mode_q == CMP_ACC) begin
            acc       <= acc_d;
            acc_empty <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
